population_reader: RTL and testbench

POPULATION_READER -- requirements
Module: population_reader

---
 rtl/ga_pkg.sv | 19 +
 rtl/population_reader.sv | 167 ++++++++++++++++
 tb/tb_population_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// ---------------------------------------------------------------------------
// ga_pkg
// Shared definitions for the genetic-algorithm datapath blocks.
//   - reader_state_t           : state encoding of the population reader FSM
//   - DEFAULT_CHROMOSOME_WIDTH : default bits per chromosome
//   - DEFAULT_POPULATION_SIZE  : default number of population memory entries
// ---------------------------------------------------------------------------
package ga_pkg;

   localparam int DEFAULT_CHROMOSOME_WIDTH = 8;
   localparam int DEFAULT_POPULATION_SIZE  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FINISH = 2'd2
   } reader_state_t;

endpackage : ga_pkg

// File: rtl/population_reader.sv
// ---------------------------------------------------------------------------
// population_reader
// Streams a contiguous (wrapping) window of the population memory out over a
// valid/ready interface, one chromosome per beat.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst_n          : synchronous active-low reset
//   start          : request a pass (only looked at while idle)
//   start_addr     : first entry to read (out-of-range values read from 0)
//   count          : number of entries to stream (saturated to the memory size)
//   abort          : terminate the current pass
//   mem_read_addr  : address to the memory's combinational read port
//   mem_read_data  : data returned for mem_read_addr in the same cycle
//   out_valid      : out_data/out_index/out_last hold a beat
//   out_ready      : consumer accepts the current beat
//   out_data       : chromosome value
//   out_index      : memory address the beat was read from
//   out_last       : final beat of the pass
//   busy           : high while streaming
//   done           : one-cycle pulse when a pass completes or aborts
// ---------------------------------------------------------------------------
module population_reader
   import ga_pkg::*;
#(
   parameter int CHROMOSOME_WIDTH = DEFAULT_CHROMOSOME_WIDTH,
   parameter int POPULATION_SIZE  = DEFAULT_POPULATION_SIZE,
   parameter int ADDR_WIDTH       = $clog2(POPULATION_SIZE)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [ADDR_WIDTH-1:0]       start_addr,
   input  logic [ADDR_WIDTH:0]         count,
   input  logic                        abort,
   output logic [ADDR_WIDTH-1:0]       mem_read_addr,
   input  logic [CHROMOSOME_WIDTH-1:0] mem_read_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHROMOSOME_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0]       out_index,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done
);

   // The count port is one bit wider than the address, so the population
   // size always fits in it and can serve as the saturation limit.
   localparam logic [ADDR_WIDTH:0]   POP_SIZE_CNT = (ADDR_WIDTH+1)'(POPULATION_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(POPULATION_SIZE - 1);
   localparam logic [ADDR_WIDTH:0]   ONE_CNT      = (ADDR_WIDTH+1)'(1);

   reader_state_t               state_q, state_d;
   logic [ADDR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]         remaining_q, remaining_d;
   logic                        out_valid_q, out_valid_d;
   logic [CHROMOSOME_WIDTH-1:0] out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0]       out_index_q, out_index_d;
   logic                        out_last_q, out_last_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   logic                        xfer;
   logic                        load;

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      xfer        = out_valid_q && out_ready;
      load        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  rd_ptr_d    = ({1'b0, start_addr} >= POP_SIZE_CNT) ? '0 : start_addr;
                  remaining_d = (count > POP_SIZE_CNT) ? POP_SIZE_CNT : count;
                  state_d     = ST_STREAM;
               end else begin
                  state_d     = ST_FINISH;
               end
            end
         end

         ST_STREAM: begin
            if (abort) begin
               // Abort wins over any load or transfer in the same cycle.
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               remaining_d = '0;
               state_d     = ST_FINISH;
            end else begin
               if (xfer) begin
                  out_valid_d = 1'b0;
                  if (out_last_q) begin
                     state_d = ST_FINISH;
                  end
               end
               // Refill the output register whenever it is empty or being
               // drained this cycle; this keeps one beat per cycle under
               // continuous ready. The last beat is loaded with remaining==1,
               // so a last-beat transfer never coincides with a load.
               load = (remaining_q != '0) && (!out_valid_q || out_ready);
               if (load) begin
                  out_valid_d = 1'b1;
                  out_data_d  = mem_read_data;
                  out_index_d = rd_ptr_q;
                  out_last_d  = (remaining_q == ONE_CNT);
                  rd_ptr_d    = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
                  remaining_d = remaining_q - ONE_CNT;
               end
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // exactly with the state they describe.
      busy_d = (state_d == ST_STREAM);
      done_d = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_read_addr = rd_ptr_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_index     = out_index_q;
   assign out_last      = out_last_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule : population_reader

// File: tb/tb_population_reader.sv
// ---------------------------------------------------------------------------
// tb_population_reader
// Self-checking bench for population_reader. A behavioural model builds the
// list of (index, data) beats a pass must produce from start_addr/count and
// the memory image; the bench drives consumer back-pressure and aborts and
// compares every transferred beat, stall stability, done timing and status.
// ---------------------------------------------------------------------------
module tb_population_reader;

   localparam int CW = 8;
   localparam int PS = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic          abort;
   logic [AW-1:0] mem_read_addr;
   logic [CW-1:0] mem_read_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy;
   logic          done;

   logic [CW-1:0] mem [PS];

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_read_addr];

   population_reader #(
      .CHROMOSOME_WIDTH(CW),
      .POPULATION_SIZE (PS),
      .ADDR_WIDTH      (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_addr   (start_addr),
      .count        (count),
      .abort        (abort),
      .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_index    (out_index),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int idx;
      int data;
   } beat_t;

   beat_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete pass. mode: 0 = ready held high, 1 = ready 1,0,0 repeating,
   // 2 = random ready. abort_after > 0 aborts once that many beats transferred.
   task automatic run_pass(input int sa, input int cnt, input int mode,
                           input int abort_after, input string tag);
      int     base, n, xfers, cyc, done_cnt, done_cyc, last_cyc, abort_cyc;
      int     first_v_cyc, spurious, exp_done;
      logic   stalled, aborted, abort_prev, abort_now, rdy;
      logic [CW-1:0] pd;
      logic [AW-1:0] pi;
      logic   pl;
      beat_t  b;

      // Reference: saturated count, out-of-range start reads from 0, wrap mod PS.
      exp_q.delete();
      base = (sa >= PS) ? 0 : sa;
      n    = (cnt > PS) ? PS : cnt;
      for (int k = 0; k < n; k++) begin
         b.idx  = (base + k) % PS;
         b.data = int'(mem[(base + k) % PS]);
         exp_q.push_back(b);
      end

      @(negedge clk);
      start      = 1'b1;
      start_addr = AW'(sa);
      count      = (AW+1)'(cnt);
      out_ready  = 1'b0;
      abort      = 1'b0;
      @(negedge clk);
      start = 1'b0;

      xfers = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
      abort_cyc = -1; first_v_cyc = -1; spurious = 0;
      stalled = 1'b0; aborted = 1'b0; abort_prev = 1'b0;
      pd = '0; pi = '0; pl = 1'b0;

      while (cyc < 300 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         if (cyc == 0) begin
            check({tag, " busy_after_start"}, 32'(busy), 32'(n > 0));
            check({tag, " no_valid_first_cycle"}, 32'(out_valid), 32'(0));
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
         if (stalled)
            check({tag, " stall_hold"}, 32'({out_valid, out_last, out_index, out_data}),
                  32'({1'b1, pl, pi, pd}));
         if (abort_prev)
            check({tag, " abort_next_cycle"}, 32'({out_valid, done, busy}), 32'(3'b010));
         if (out_valid && exp_q.size() == 0) spurious++;

         abort_now = (abort_after > 0) && !aborted && (xfers == abort_after);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         abort     = abort_now;
         out_ready = rdy;

         if (abort_now) begin
            aborted   = 1'b1;
            abort_cyc = cyc;
            exp_q.delete();
         end else if (out_valid && rdy) begin
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               check({tag, " beat"}, 32'({out_last, out_index, out_data}),
                     32'({1'(exp_q.size() == 0), AW'(b.idx), CW'(b.data)}));
               if (exp_q.size() == 0) last_cyc = cyc;
            end
            xfers++;
         end

         stalled    = out_valid && !rdy && !abort_now;
         pd         = out_data;
         pi         = out_index;
         pl         = out_last;
         abort_prev = abort_now;
         @(negedge clk);
         cyc++;
      end
      abort     = 1'b0;
      out_ready = 1'b0;

      if (n == 0)           exp_done = 0;
      else if (aborted)     exp_done = abort_cyc + 1;
      else                  exp_done = last_cyc + 1;

      check({tag, " transfers"}, 32'(xfers), 32'((abort_after > 0) ? abort_after : n));
      check({tag, " done_pulses"}, 32'(done_cnt), 32'(1));
      check({tag, " done_time"}, 32'(done_cyc), 32'(exp_done));
      check({tag, " spurious_valid"}, 32'(spurious), 32'(0));
      if (n > 0) check({tag, " first_valid_latency"}, 32'(first_v_cyc), 32'(1));
      check({tag, " idle_after"}, 32'({busy, out_valid, done}), 32'(0));
      $display("pass %s: start_addr=%0d count=%0d mode=%0d abort_after=%0d transfers=%0d done_cycle=%0d",
               tag, sa, cnt, mode, abort_after, xfers, done_cyc);
   endtask

   initial begin
      int sa, cnt, ab, n;
      int done_seen;

      rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
      abort = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < PS; i++) mem[i] = CW'(8'hA0 + i);

      repeat (2) @(negedge clk);
      check("reset_outputs",
            32'({out_valid, out_last, out_data, out_index, busy, done, mem_read_addr}), 32'(0));
      rst_n = 1'b1;

      run_pass(0, 16, 0, 0, "full");
      run_pass(14, 4, 0, 0, "wrap");
      run_pass(0, 5, 1, 0, "stall");
      run_pass(0, 0, 0, 0, "zero");
      run_pass(0, 20, 0, 0, "saturate");
      run_pass(2, 10, 0, 3, "abort");
      run_pass(5, 6, 2, 0, "after_abort");

      // Reset in the middle of a pass: everything clears, no done pulse.
      @(negedge clk);
      start = 1'b1; start_addr = AW'(3); count = (AW+1)'(10); out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midpass_reset_outputs",
            32'({out_valid, out_last, out_data, out_index, busy, done, mem_read_addr}), 32'(0));
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || out_valid) done_seen++;
      end
      check("midpass_reset_quiet", 32'(done_seen), 32'(0));
      $display("pass midpass_reset: outputs cleared, activity_after=%0d", done_seen);
      out_ready = 1'b0;
      run_pass(9, 8, 2, 0, "after_reset");

      // Randomised passes over a random memory image.
      for (int i = 0; i < PS; i++) mem[i] = CW'($urandom);
      for (int r = 0; r < 8; r++) begin
         sa  = int'($urandom_range(0, PS - 1));
         cnt = int'($urandom_range(0, 2 * PS - 1));
         n   = (cnt > PS) ? PS : cnt;
         ab  = (n > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : 0;
         run_pass(sa, cnt, int'($urandom_range(0, 2)), ab, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_population_reader
